// File: rtl/ascon_block_feeder.sv
// Block feeder for the Ascon FSM: host FIFO plus per-request block issue.
// Optional stall counter output enabled by ASCON_FEEDER_STALL_CNT_EN.
module ascon_block_feeder #(
  parameter int DATA_W    = 64,
  parameter int DEPTH     = 4,
  parameter int NB_BLOCKS = 4
) (
  input  logic              clock_i,
  input  logic              resetb_i,
  input  logic              start_i,
  input  logic              host_valid_i,
  input  logic [DATA_W-1:0] host_data_i,
  output logic              host_ready_o,
  input  logic              block_req_i,
  output logic              data_valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        block_idx_o,
  output logic              last_block_o,
  output logic              pending_o,
`ifdef ASCON_FEEDER_STALL_CNT_EN
  output logic [15:0]       stall_cnt_o,
`endif
  output logic              busy_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ISSUE,
    S_DONE
  } state_t;

  state_t state;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [1:0]        n;

  logic empty;
  logic push;
  logic pop;

  assign empty        = (count == '0);
  assign host_ready_o = (count < CW'(DEPTH));
  assign push         = host_valid_i && host_ready_o;

  // The pop happens on the edge that enters ISSUE so data_o is
  // already valid while data_valid_o is high.
  assign pop = (state == S_WAIT) && !start_i && !empty &&
               (block_req_i || pending_o);

  always_ff @(posedge clock_i) begin
    if (push) begin
      mem[wr_ptr] <= host_data_i;
    end
  end

  always_ff @(posedge clock_i) begin
    if (!resetb_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock_i) begin
    if (!resetb_i) begin
      state        <= S_IDLE;
      n            <= '0;
      data_valid_o <= 1'b0;
      data_o       <= '0;
      block_idx_o  <= '0;
      last_block_o <= 1'b0;
      pending_o    <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      data_valid_o <= 1'b0;
      if (start_i) begin
        state     <= S_WAIT;
        busy_o    <= 1'b1;
        n         <= '0;
        pending_o <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            state <= S_IDLE;
          end
          S_WAIT: begin
            if (pop) begin
              state        <= S_ISSUE;
              data_o       <= mem[rd_ptr];
              block_idx_o  <= n;
              last_block_o <= (n == 2'(NB_BLOCKS - 1));
              data_valid_o <= 1'b1;
              pending_o    <= 1'b0;
              n            <= n + 1'b1;
            end else if (block_req_i) begin
              pending_o <= 1'b1;
            end
          end
          S_ISSUE: begin
            if (last_block_o) begin
              state  <= S_DONE;
              busy_o <= 1'b0;
            end else begin
              state <= S_WAIT;
            end
          end
          S_DONE: begin
            state  <= S_IDLE;
            busy_o <= 1'b0;
          end
          default: begin
            state  <= S_IDLE;
            busy_o <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef ASCON_FEEDER_STALL_CNT_EN
  always_ff @(posedge clock_i) begin
    if (!resetb_i || start_i) begin
      stall_cnt_o <= '0;
    end else if (pending_o && stall_cnt_o != 16'hFFFF) begin
      stall_cnt_o <= stall_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ascon_block_feeder.sv
// Scoreboard bench for ascon_block_feeder.
// Expected blocks are queued at request time and checked on data_valid_o.
module tb_ascon_block_feeder;

  logic        clk = 1'b0;
  logic        resetb;
  logic        start;
  logic        host_valid;
  logic [63:0] host_data;
  logic        host_ready;
  logic        block_req;
  logic        data_valid;
  logic [63:0] data;
  logic [1:0]  block_idx;
  logic        last_block;
  logic        pending;
  logic        busy;
`ifdef ASCON_FEEDER_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  ascon_block_feeder dut (
    .clock_i      (clk),
    .resetb_i     (resetb),
    .start_i      (start),
    .host_valid_i (host_valid),
    .host_data_i  (host_data),
    .host_ready_o (host_ready),
    .block_req_i  (block_req),
    .data_valid_o (data_valid),
    .data_o       (data),
    .block_idx_o  (block_idx),
    .last_block_o (last_block),
    .pending_o    (pending),
`ifdef ASCON_FEEDER_STALL_CNT_EN
    .stall_cnt_o  (stall_cnt),
`endif
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] d;
    logic [1:0]  idx;
    logic        last;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  logic prev_v = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (data_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", 64'(data_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("blk_data", data, e.d);
        chk("blk_idx", 64'(block_idx), 64'(e.idx));
        chk("blk_last", 64'(last_block), 64'(e.last));
        chk("blk_latency", 64'(cyc), 64'(e.cyc));
      end
      if (prev_v) chk("valid_back2back", 64'(prev_v), 64'd0);
    end
    prev_v = (data_valid === 1'b1);
  end

  task automatic tick(input int k = 1);
    repeat (k) @(negedge clk);
  endtask

  task automatic expect_blk(input logic [63:0] d, input int idx,
                            input int lat);
    exp_t e;
    e.d    = d;
    e.idx  = idx[1:0];
    e.last = (idx == 3);
    e.cyc  = cyc + lat;
    sb.push_back(e);
  endtask

  task automatic wr(input logic [63:0] d);
    host_valid = 1'b1;
    host_data  = d;
    tick();
    host_valid = 1'b0;
  endtask

  task automatic rq();
    block_req = 1'b1;
    tick();
    block_req = 1'b0;
  endtask

  task automatic st();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  logic [63:0] pre [4];

  initial begin
    pre[0] = 64'h1111_1111_1111_1111;
    pre[1] = 64'h2222_2222_2222_2222;
    pre[2] = 64'h3333_3333_3333_3333;
    pre[3] = 64'h4444_4444_4444_4444;
    resetb = 1'b0;
    start = 1'b0;
    host_valid = 1'b0;
    host_data = '0;
    block_req = 1'b0;
    tick(2);
    resetb = 1'b1;
    tick();

    chk("rst_ready", 64'(host_ready), 64'd1);
    chk("rst_valid", 64'(data_valid), 64'd0);
    chk("rst_data", data, 64'd0);
    chk("rst_idx", 64'(block_idx), 64'd0);
    chk("rst_last", 64'(last_block), 64'd0);
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
`ifdef ASCON_FEEDER_STALL_CNT_EN
    chk("rst_stall", 64'(stall_cnt), 64'd0);
`endif
    rq();
    tick(3);
    chk("idle_pending", 64'(pending), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);

    for (int i = 0; i < 4; i++) wr(pre[i]);
    chk("preload_full", 64'(host_ready), 64'd0);
    st();
    chk("start_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 4; i++) begin
      expect_blk(pre[i], i, 1);
      rq();
      tick(19);
    end
    chk("done_busy", 64'(busy), 64'd0);
    chk("done_data", data, pre[3]);
    chk("done_last", 64'(last_block), 64'd1);
    chk("done_ready", 64'(host_ready), 64'd1);

    st();
    rq();
    chk("pend_set", 64'(pending), 64'd1);
    tick(6);
    expect_blk(64'hA5A5_A5A5_A5A5_A5A5, 0, 2);
    wr(64'hA5A5_A5A5_A5A5_A5A5);
    tick(2);
    chk("pend_clr", 64'(pending), 64'd0);
`ifdef ASCON_FEEDER_STALL_CNT_EN
    chk("stall_cnt", 64'(stall_cnt), 64'd8);
`endif

    st();
    for (int i = 0; i < 4; i++) wr(64'hB0 + 64'(i));
    chk("bb_full", 64'(host_ready), 64'd0);
    host_valid = 1'b1;
    host_data  = 64'hB4;
    tick(2);
    chk("bb_held_off", 64'(host_ready), 64'd0);
    expect_blk(64'hB0, 0, 1);
    rq();
    chk("bb_reopen", 64'(host_ready), 64'd1);
    tick();
    host_valid = 1'b0;
    chk("bb_full_again", 64'(host_ready), 64'd0);

    tick(3);
    expect_blk(64'hB1, 1, 1);
    rq();
    tick(3);
    st();
    expect_blk(64'hB2, 0, 1);
    rq();
    tick(3);
    expect_blk(64'hB3, 1, 1);
    rq();
    tick(3);
    expect_blk(64'hB4, 2, 1);
    rq();
    tick(3);
    chk("rs_ready", 64'(host_ready), 64'd1);
    wr(64'hC0);
    expect_blk(64'hC0, 3, 1);
    rq();
    tick(3);
    chk("rs_busy", 64'(busy), 64'd0);

    st();
    host_valid = 1'b1;
    host_data  = 64'hD0;
    expect_blk(64'hD0, 0, 2);
    rq();
    host_valid = 1'b0;
    chk("same_pend", 64'(pending), 64'd1);
    tick(3);

    rq();
    chk("pr_pend", 64'(pending), 64'd1);
    host_valid = 1'b1;
    host_data  = 64'hE0;
    tick();
    host_data = 64'hE1;
    resetb    = 1'b0;
    chk("pr_pend_hold", 64'(pending), 64'd1);
    tick();
    resetb     = 1'b1;
    host_valid = 1'b0;
    chk("ar_pending", 64'(pending), 64'd0);
    chk("ar_data", data, 64'd0);
    chk("ar_idx", 64'(block_idx), 64'd0);
    chk("ar_ready", 64'(host_ready), 64'd1);
    chk("ar_busy", 64'(busy), 64'd0);
    rq();
    tick(3);
    chk("ar_idle_busy", 64'(busy), 64'd0);
    st();
    rq();
    chk("ar_fifo_empty", 64'(pending), 64'd1);
    expect_blk(64'hF0, 0, 2);
    wr(64'hF0);
    tick(5);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
